// File: rtl/fetch_if_id_pkg.sv
// fetch_if_id_pkg
// Definitions shared by the pipeline stages: instruction width, the NOP
// encoding used for bubbles, the Rs/Rt field positions, and the Fetch_State
// encodings. The include guard lets any stage pull this file in.
// No ports (package only).
`ifndef FETCH_IF_ID_PKG_SV
`define FETCH_IF_ID_PKG_SV
package fetch_if_id_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  localparam logic [1:0] FS_RUN   = 2'd0;
  localparam logic [1:0] FS_HOLD  = 2'd1;
  localparam logic [1:0] FS_FLUSH = 2'd2;

  // Word-align a fetch address by clearing its byte-offset bits.
  function automatic logic [INSTR_W-1:0] pc_align(input logic [INSTR_W-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage
`endif

// File: rtl/fetch_if_id_sat_counter.sv
// sat_counter
// Event counter that increments on inc and sticks at all-ones.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous active-high clear
//   inc   - count one event this cycle
//   count - current count (CNT_W bits)
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_if_id.sv
// fetch_if_id
// Instruction-fetch stage plus IF/ID pipeline register.
// Ports:
//   clk, reset                      - clock and synchronous active-high reset
//   Stall_Data_Hazard               - freeze PC and IF/ID this cycle
//   Branch_Taken / Branch_Target    - redirect from a taken branch (wins)
//   Jump / Jump_Target              - redirect from a jump
//   Instr_IMem                      - combinational IMEM data for PC_IMem
//   PC_IMem                         - fetch address (the PC register)
//   Instruction_IF_ID, PCPlus4_IF_ID, Valid_IF_ID - IF/ID contents
//   RegisterRs_IF_ID, RegisterRt_IF_ID            - IF/ID source fields
//   Fetch_State                     - last cycle's action (RUN/HOLD/FLUSH)
//   Stall_Count, Flush_Count        - saturating event counters
module fetch_if_id
  import fetch_if_id_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Stall_Data_Hazard,
  input  logic             Branch_Taken,
  input  logic [31:0]      Branch_Target,
  input  logic             Jump,
  input  logic [31:0]      Jump_Target,
  input  logic [31:0]      Instr_IMem,
  output logic [31:0]      PC_IMem,
  output logic [31:0]      Instruction_IF_ID,
  output logic [31:0]      PCPlus4_IF_ID,
  output logic             Valid_IF_ID,
  output logic [4:0]       RegisterRs_IF_ID,
  output logic [4:0]       RegisterRt_IF_ID,
  output logic [1:0]       Fetch_State,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);

  logic [31:0] pc_p0;
  logic [31:0] pc_plus4_p0;
  logic [31:0] instr_p1;
  logic [31:0] pc_plus4_p1;
  logic        vld_p1;
  logic [1:0]  state;
  logic        redirect;
  logic [31:0] target;

  assign pc_plus4_p0 = pc_p0 + 32'd4;
  assign redirect    = Branch_Taken | Jump;
  assign target      = Branch_Taken ? Branch_Target : Jump_Target;

  // IF -> ID boundary: a stall freezes everything, including the redirect,
  // because ID re-resolves the branch with forwarded operands next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0       <= PC_RESET;
      instr_p1    <= NOP;
      pc_plus4_p1 <= '0;
      vld_p1      <= 1'b0;
      state       <= FS_RUN;
    end else if (Stall_Data_Hazard) begin
      state <= FS_HOLD;
    end else if (redirect) begin
      pc_p0       <= pc_align(target);
      instr_p1    <= NOP;
      pc_plus4_p1 <= '0;
      vld_p1      <= 1'b0;
      state       <= FS_FLUSH;
    end else begin
      pc_p0       <= pc_plus4_p0;
      instr_p1    <= Instr_IMem;
      pc_plus4_p1 <= pc_plus4_p0;
      vld_p1      <= 1'b1;
      state       <= FS_RUN;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (Stall_Data_Hazard),
    .count (Stall_Count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!Stall_Data_Hazard && redirect),
    .count (Flush_Count)
  );

  assign PC_IMem           = pc_p0;
  assign Instruction_IF_ID = instr_p1;
  assign PCPlus4_IF_ID     = pc_plus4_p1;
  assign Valid_IF_ID       = vld_p1;
  assign Fetch_State       = state;
  // Bubbles hold NOP, so these read register 0 and never match in the hazard unit.
  assign RegisterRs_IF_ID  = instr_p1[RS_MSB:RS_LSB];
  assign RegisterRt_IF_ID  = instr_p1[RT_MSB:RT_LSB];

endmodule
